// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file.
// Two combinational read ports bypass the value committing at the next edge.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [DATA_W-1:0] wr_dout,
   input  logic [DATA_W-1:0] wr_alu_result,
   input  logic [ADDR_W-1:0] wr_Rw,
   input  logic              wr_RegWr,
   input  logic              wr_Jump,
   input  logic              wr_MemtoReg,
   input  logic [ADDR_W-1:0] Ra,
   input  logic [ADDR_W-1:0] Rb,
   output logic [DATA_W-1:0] busA,
   output logic [DATA_W-1:0] busB,
   output logic [DATA_W-1:0] busW,
   output logic              wb_we,
   output logic [CNT_W-1:0]  wr_cnt
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_r [NREG];
   logic [CNT_W-1:0]  wr_cnt_r;
   logic [DATA_W-1:0] bus_w_s;
   logic              wb_we_s;
   logic [DATA_W-1:0] bus_a_s;
   logic [DATA_W-1:0] bus_b_s;

   // Write-back value select and effective write enable
   always_comb begin
      bus_w_s = wr_alu_result;
      if (wr_MemtoReg) begin
         bus_w_s = wr_dout;
      end else begin
         bus_w_s = wr_alu_result;
      end
      wb_we_s = wr_RegWr & ~wr_Jump & (wr_Rw != {ADDR_W{1'b0}});
   end

   // Read port A; reads are forced to zero while reset is held
   always_comb begin
      bus_a_s = {DATA_W{1'b0}};
      if (!Rst_n || (Ra == {ADDR_W{1'b0}})) begin
         bus_a_s = {DATA_W{1'b0}};
      end else if (wb_we_s && (wr_Rw == Ra)) begin
         bus_a_s = bus_w_s;
      end else begin
         bus_a_s = regs_r[Ra];
      end
   end

   // Read port B, same rules as port A
   always_comb begin
      bus_b_s = {DATA_W{1'b0}};
      if (!Rst_n || (Rb == {ADDR_W{1'b0}})) begin
         bus_b_s = {DATA_W{1'b0}};
      end else if (wb_we_s && (wr_Rw == Rb)) begin
         bus_b_s = bus_w_s;
      end else begin
         bus_b_s = regs_r[Rb];
      end
   end

   // Register file commit; entry 0 is never written since wb_we excludes it
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wb_we_s) begin
         regs_r[wr_Rw] <= bus_w_s;
      end
   end

   // Committed-write counter, wraps naturally
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_cnt_r <= {CNT_W{1'b0}};
      end else if (wb_we_s) begin
         wr_cnt_r <= wr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         wr_cnt_r <= wr_cnt_r;
      end
   end

   assign busA   = bus_a_s;
   assign busB   = bus_b_s;
   assign busW   = bus_w_s;
   assign wb_we  = wb_we_s;
   assign wr_cnt = wr_cnt_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array-based register model.
// Counter is built 4 bits wide so wrap-around is reachable in a short run.
module tb_wb_regfile;

   logic        Clk;
   logic        Rst_n;
   logic [31:0] wr_dout;
   logic [31:0] wr_alu_result;
   logic [4:0]  wr_Rw;
   logic        wr_RegWr;
   logic        wr_Jump;
   logic        wr_MemtoReg;
   logic [4:0]  Ra;
   logic [4:0]  Rb;
   logic [31:0] busA;
   logic [31:0] busB;
   logic [31:0] busW;
   logic        wb_we;
   logic [3:0]  wr_cnt;

   int          test_cnt;
   int          fail_cnt;
   logic [31:0] model_regs [32];
   int          model_cnt;

   wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .wr_dout(wr_dout), .wr_alu_result(wr_alu_result),
      .wr_Rw(wr_Rw), .wr_RegWr(wr_RegWr), .wr_Jump(wr_Jump), .wr_MemtoReg(wr_MemtoReg),
      .Ra(Ra), .Rb(Rb), .busA(busA), .busB(busB), .busW(busW), .wb_we(wb_we),
      .wr_cnt(wr_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                              input logic [4:0] rw, input logic [31:0] w);
      if (idx == 5'd0) return 32'd0;
      if (we && rw == idx) return w;
      return model_regs[idx];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_cnt = 0;
   endtask

   // Apply one MEM/WB beat at the negedge, check combinational outputs, then commit
   task automatic beat(input logic [4:0] rw, input logic regwr, input logic jump,
                       input logic m2r, input logic [31:0] dout, input logic [31:0] alu,
                       input logic [4:0] ra, input logic [4:0] rb);
      logic [31:0] exp_w;
      logic        exp_we;
      wr_Rw = rw; wr_RegWr = regwr; wr_Jump = jump; wr_MemtoReg = m2r;
      wr_dout = dout; wr_alu_result = alu; Ra = ra; Rb = rb;
      #1;
      exp_w  = m2r ? dout : alu;
      exp_we = regwr && !jump && (rw != 5'd0);
      check_eq("busW", busW, exp_w);
      check_eq("wb_we", {31'd0, wb_we}, {31'd0, exp_we});
      check_eq("busA", busA, model_read(ra, exp_we, rw, exp_w));
      check_eq("busB", busB, model_read(rb, exp_we, rw, exp_w));
      check_eq("wr_cnt", {28'd0, wr_cnt}, model_cnt);
      @(posedge Clk);
      if (exp_we) begin
         model_regs[rw] = exp_w;
         model_cnt = (model_cnt + 1) % 16;
      end
      @(negedge Clk);
   endtask

   task automatic idle_read(input logic [4:0] ra, input logic [4:0] rb);
      beat(5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, ra, rb);
   endtask

   initial begin
      test_cnt = 0;
      fail_cnt = 0;
      model_reset();
      Rst_n = 1'b0;
      wr_Rw = 5'd0; wr_RegWr = 1'b0; wr_Jump = 1'b0; wr_MemtoReg = 1'b0;
      wr_dout = 32'd0; wr_alu_result = 32'd0; Ra = 5'd5; Rb = 5'd31;
      @(negedge Clk);
      #1;
      check_eq("rst_busA", busA, 32'd0);
      check_eq("rst_busB", busB, 32'd0);
      check_eq("rst_cnt", {28'd0, wr_cnt}, 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;

      // write r5 then reset asynchronously
      beat(5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_1234, 5'd5, 5'd1);
      idle_read(5'd5, 5'd5);
      wr_Rw = 5'd5; wr_RegWr = 1'b1; wr_alu_result = 32'hABCD_0001; Ra = 5'd5; Rb = 5'd5;
      #2;
      Rst_n = 1'b0;
      #1;
      check_eq("async_rst_busA", busA, 32'd0);
      check_eq("async_rst_busB_bypass", busB, 32'd0);
      check_eq("async_rst_cnt", {28'd0, wr_cnt}, 32'd0);
      model_reset();
      @(posedge Clk);
      @(negedge Clk);
      check_eq("no_write_in_rst", {28'd0, wr_cnt}, 32'd0);
      Rst_n = 1'b1;
      idle_read(5'd5, 5'd0);

      // ALU write, load with dual bypass
      beat(5'd3, 1'b1, 1'b0, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 5'd3, 5'd2);
      idle_read(5'd3, 5'd3);
      beat(5'd7, 1'b1, 1'b0, 1'b1, 32'h0000_55AA, 32'h9999_9999, 5'd7, 5'd7);
      idle_read(5'd7, 5'd3);

      // $0 and jump inhibit
      beat(5'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      beat(5'd4, 1'b1, 1'b1, 1'b0, 32'd0, 32'h4444_4444, 5'd4, 5'd4);
      idle_read(5'd4, 5'd0);

      // back-to-back writes to r9
      beat(5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1, 5'd9, 5'd3);
      beat(5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 32'd2, 5'd9, 5'd9);
      idle_read(5'd9, 5'd9);

      // counter wrap: 16 valid writes from reset
      @(negedge Clk);
      Rst_n = 1'b0;
      #1;
      model_reset();
      Rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         beat(5'((i % 31) + 1), 1'b1, 1'b0, 1'b0, 32'd0, 32'(i * 3 + 1), 5'd1, 5'd16);
      end
      check_eq("cnt_wrap", {28'd0, wr_cnt}, 32'd0);
      beat(5'd2, 1'b1, 1'b0, 1'b0, 32'd0, 32'h2222, 5'd2, 5'd1);
      beat(5'd6, 1'b1, 1'b0, 1'b0, 32'd0, 32'h6666, 5'd6, 5'd2);

      // mid-write reset pulse, released before the edge so the write still commits
      wr_Rw = 5'd8; wr_RegWr = 1'b1; wr_Jump = 1'b0; wr_MemtoReg = 1'b0;
      wr_alu_result = 32'h8888_0000; Ra = 5'd6; Rb = 5'd2;
      #1;
      Rst_n = 1'b0;
      #1;
      check_eq("pulse_cnt", {28'd0, wr_cnt}, 32'd0);
      check_eq("pulse_busA", busA, 32'd0);
      Rst_n = 1'b1;
      model_reset();
      #1;
      check_eq("pulse_r6_cleared", busA, 32'd0);
      @(posedge Clk);
      model_regs[8] = 32'h8888_0000;
      model_cnt = 1;
      @(negedge Clk);
      idle_read(5'd8, 5'd6);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [4:0] rw;
         logic [4:0] ra;
         logic [4:0] rb;
         rw = 5'($urandom_range(0, 31));
         ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
         rb = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
         beat(rw, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 1)), $urandom, $urandom, ra, rb);
      end
      for (int i = 0; i < 32; i += 2) begin
         idle_read(5'(i), 5'(i + 1));
      end

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
